// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the 3BC fetch sequencer.
package fetch_unit_pkg;
    localparam int PC_W_DEF   = 10;
    localparam int LUT_IW_DEF = 3;
    localparam int CYC_W_DEF  = 16;

    // Encoding of the halt instruction that makes Ctrl raise Ack.
    localparam logic [8:0] kHALT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch handshake bundle: Start/Done, Ctrl decode inputs and PC/status outputs.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_IW = LUT_IW_DEF,
    parameter int CYC_W  = CYC_W_DEF
);
    logic              Start;
    logic [PC_W-1:0]   StartAddr;
    logic              Stall;
    logic              Ack;
    logic              BranchTkn;
    logic [LUT_IW-1:0] TargetIdx;
    logic [PC_W-1:0]   ProgCtr;
    logic              Running;
    logic              Done;
    logic [CYC_W-1:0]  CycleCt;

    modport master (
        output Start, StartAddr, Stall, Ack, BranchTkn, TargetIdx,
        input  ProgCtr, Running, Done, CycleCt
    );

    modport slave (
        input  Start, StartAddr, Stall, Ack, BranchTkn, TargetIdx,
        output ProgCtr, Running, Done, CycleCt
    );
endinterface

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-target table; contents belong to the loaded program.
module jump_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_IW = LUT_IW_DEF
) (
    input  logic [LUT_IW-1:0] idx,
    output logic [PC_W-1:0]   target
);
    always_comb begin
        target = '0;
        case (int'(idx))
            0:       target = PC_W'('h100);
            1:       target = PC_W'('h180);
            2:       target = PC_W'('h200);
            3:       target = PC_W'('h120);
            default: target = '0;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer: state register, PC, RUN-cycle counter
// and the next-PC mux fed by the jump LUT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_IW = LUT_IW_DEF,
    parameter int CYC_W  = CYC_W_DEF
) (
    input logic         Clk,
    input logic         Reset_n,
    fetch_unit_if.slave bus
);
    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic [CYC_W-1:0] cycles;
    logic             done;

    jump_lut #(.PC_W(PC_W), .LUT_IW(LUT_IW)) u_lut (
        .idx    (bus.TargetIdx),
        .target (target)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            pc     <= '0;
            cycles <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Start) state <= ARM;
                ARM: begin
                    pc     <= bus.StartAddr;
                    cycles <= '0;
                    done   <= 1'b0;
                    if (!bus.Start) state <= RUN;
                end
                RUN: begin
                    // Every RUN edge counts, stalled or not; saturate rather than wrap.
                    if (cycles != '1) cycles <= cycles + CYC_W'(1);
                    if (bus.Start) begin
                        state <= ARM;
                    end else if (bus.Stall) begin
                        state <= RUN;
                    end else if (bus.Ack) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else if (bus.BranchTkn) begin
                        pc <= target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                HALT: if (bus.Start) state <= ARM;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ProgCtr = pc;
    assign bus.Running = (state == RUN);
    assign bus.Done    = done;
    assign bus.CycleCt = cycles;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: run, branch, halt, stall, wrap, abort, reset.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if #(.PC_W(10), .LUT_IW(3), .CYC_W(16)) bus ();

    fetch_unit #(.PC_W(10), .LUT_IW(3), .CYC_W(16)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and checks both sit 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start held for two edges then released: ends on the first RUN cycle.
    task automatic start_at(input logic [9:0] addr);
        bus.StartAddr = addr;
        bus.Start = 1'b1;
        step();
        step();
        bus.Start = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.Start = 1'b0;
        bus.StartAddr = '0;
        bus.Stall = 1'b0;
        bus.Ack = 1'b0;
        bus.BranchTkn = 1'b0;
        bus.TargetIdx = '0;
        step();
        check("rst_pc", 32'(bus.ProgCtr), 32'h0);
        check("rst_running", 32'(bus.Running), 32'h0);
        check("rst_done", 32'(bus.Done), 32'h0);
        check("rst_cyc", 32'(bus.CycleCt), 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_hold", 32'(bus.Running), 32'h0);

        // Sequential run from 0x010
        start_at(10'h010);
        check("seq_first_pc", 32'(bus.ProgCtr), 32'h010);
        check("seq_running", 32'(bus.Running), 32'h1);
        for (int i = 0; i < 4; i++) step();
        check("seq_pc", 32'(bus.ProgCtr), 32'h014);
        check("seq_cyc", 32'(bus.CycleCt), 32'd4);

        // Branch via LUT[3]
        start_at(10'h012);
        bus.BranchTkn = 1'b1;
        bus.TargetIdx = 3'd3;
        step();
        check("br_target", 32'(bus.ProgCtr), 32'h120);
        bus.BranchTkn = 1'b0;
        step();
        check("br_next", 32'(bus.ProgCtr), 32'h121);

        // Halt wins over branch
        start_at(10'h030);
        bus.Ack = 1'b1;
        bus.BranchTkn = 1'b1;
        step();
        bus.Ack = 1'b0;
        bus.BranchTkn = 1'b0;
        check("halt_pc", 32'(bus.ProgCtr), 32'h030);
        check("halt_done", 32'(bus.Done), 32'h1);
        check("halt_running", 32'(bus.Running), 32'h0);
        check("halt_cyc", 32'(bus.CycleCt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_hold_done", 32'(bus.Done), 32'h1);
            check("halt_hold_pc", 32'(bus.ProgCtr), 32'h030);
        end
        bus.StartAddr = 10'h040;
        bus.Start = 1'b1;
        step();
        check("rearm_done_still", 32'(bus.Done), 32'h1);
        step();
        check("rearm_done_clr", 32'(bus.Done), 32'h0);
        check("rearm_pc", 32'(bus.ProgCtr), 32'h040);
        bus.Start = 1'b0;
        step();
        check("rearm_running", 32'(bus.Running), 32'h1);

        // Stall with Ack present: Ack must be ignored
        bus.Stall = 1'b1;
        bus.Ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(bus.ProgCtr), 32'h040);
            check("stall_running", 32'(bus.Running), 32'h1);
        end
        check("stall_cyc", 32'(bus.CycleCt), 32'd3);
        check("stall_done", 32'(bus.Done), 32'h0);
        bus.Stall = 1'b0;
        bus.Ack = 1'b0;
        step();
        check("post_stall_pc", 32'(bus.ProgCtr), 32'h041);
        check("post_stall_cyc", 32'(bus.CycleCt), 32'd4);

        // Wrap at top of ROM
        start_at(10'h3FF);
        step();
        check("wrap_pc", 32'(bus.ProgCtr), 32'h000);
        check("wrap_cyc", 32'(bus.CycleCt), 32'd1);

        // Abort from RUN
        bus.StartAddr = 10'h055;
        bus.Start = 1'b1;
        step();
        check("abort_arm", 32'(bus.Running), 32'h0);
        step();
        check("abort_pc", 32'(bus.ProgCtr), 32'h055);
        check("abort_cyc", 32'(bus.CycleCt), 32'd0);
        bus.Start = 1'b0;
        step();
        check("abort_run_pc", 32'(bus.ProgCtr), 32'h055);
        check("abort_running", 32'(bus.Running), 32'h1);

        // Async reset mid-RUN at PC=5, observed before any edge
        start_at(10'h000);
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_pc", 32'(bus.ProgCtr), 32'h005);
        rst_n = 1'b0;
        #1;
        check("async_pc", 32'(bus.ProgCtr), 32'h0);
        check("async_done", 32'(bus.Done), 32'h0);
        check("async_running", 32'(bus.Running), 32'h0);
        check("async_cyc", 32'(bus.CycleCt), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(bus.Running), 32'h0);
        check("post_rst_pc", 32'(bus.ProgCtr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
